systolic_array_os_stream: RTL

SYSTOLIC_ARRAY_OS_STREAM -- requirements
Module: systolic_array_os_stream

---
 rtl/systolic_array_os_stream.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_os_stream.sv
// rtl/systolic_array_os_stream.sv - output-stationary systolic matrix multiplier with streamed A columns / B rows.
// Optional macro SYSTOLIC_SATURATE_EN: clamp each accumulate instead of wrapping.
module systolic_array_os_stream #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int IP_W   = 8,
  parameter int OP_W   = 32,
  parameter int KLEN_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [KLEN_W-1:0]          k_len,
  input  logic                       signed_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*IP_W-1:0]       input_vec,
  input  logic [COLS*IP_W-1:0]       weight_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLS*OP_W-1:0]       out_row,
  output logic [$clog2(ROWS)-1:0]    out_row_idx,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                cycles_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FC_W      = $clog2(ROWS + COLS) + 1;
  localparam int RI_W      = $clog2(ROWS);

  logic [2:0]        state;
  logic [KLEN_W-1:0] k_len_q;
  logic [KLEN_W-1:0] beat_cnt;
  logic [FC_W-1:0]   flush_cnt;
  logic              sgn_q;

  logic accept;
  logic advance;
  logic launch;

  assign accept  = (state == S_LOAD) && in_valid;
  assign advance = (state != S_IDLE);
  assign launch  = (state == S_IDLE) && start;

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  logic [IP_W-1:0] a_inj  [ROWS];
  logic [IP_W-1:0] b_inj  [COLS];
  logic [IP_W-1:0] a_edge [ROWS];
  logic [IP_W-1:0] b_edge [COLS];
  logic [IP_W-1:0] a_sk   [ROWS][ROWS];
  logic [IP_W-1:0] b_sk   [COLS][COLS];
  logic [IP_W-1:0] a_in   [ROWS][COLS];
  logic [IP_W-1:0] b_in   [ROWS][COLS];
  logic [IP_W-1:0] a_q    [ROWS][COLS];
  logic [IP_W-1:0] b_q    [ROWS][COLS];
  logic [OP_W-1:0] acc    [ROWS][COLS];
  logic [OP_W-1:0] acc_nxt[ROWS][COLS];

  function automatic logic [OP_W-1:0] mac(input logic [OP_W-1:0] acc_v,
                                          input logic [IP_W-1:0] a,
                                          input logic [IP_W-1:0] b,
                                          input logic            sgn);
    logic [2*IP_W-1:0] ps;
    logic [2*IP_W-1:0] pu;
    logic [OP_W-1:0]   ext;
`ifdef SYSTOLIC_SATURATE_EN
    logic [OP_W:0]     sum;
`endif
    ps  = $signed({{IP_W{a[IP_W-1]}}, a}) * $signed({{IP_W{b[IP_W-1]}}, b});
    pu  = {{IP_W{1'b0}}, a} * {{IP_W{1'b0}}, b};
    ext = sgn ? OP_W'($signed(ps)) : OP_W'(pu);
`ifdef SYSTOLIC_SATURATE_EN
    if (sgn) begin
      sum = {acc_v[OP_W-1], acc_v} + {ext[OP_W-1], ext};
      // One extra sign bit disagreeing with the MSB means the signed add overflowed.
      if (sum[OP_W] != sum[OP_W-1])
        return sum[OP_W] ? {1'b1, {(OP_W-1){1'b0}}} : {1'b0, {(OP_W-1){1'b1}}};
      return sum[OP_W-1:0];
    end
    sum = {1'b0, acc_v} + {1'b0, ext};
    return sum[OP_W] ? {OP_W{1'b1}} : sum[OP_W-1:0];
`else
    return acc_v + ext;
`endif
  endfunction

  // Row i of A enters the array i cycles late, column j of B j cycles late.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_edge
    assign a_inj[gi] = accept ? input_vec[gi*IP_W +: IP_W] : '0;
    if (gi == 0) begin : g_direct
      assign a_edge[gi] = a_inj[gi];
    end else begin : g_delayed
      assign a_edge[gi] = a_sk[gi][gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_col_edge
    assign b_inj[gj] = accept ? weight_vec[gj*IP_W +: IP_W] : '0;
    if (gj == 0) begin : g_direct
      assign b_edge[gj] = b_inj[gj];
    end else begin : g_delayed
      assign b_edge[gj] = b_sk[gj][gj-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_pe_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe_col
      if (gj == 0) begin : g_a_left
        assign a_in[gi][gj] = a_edge[gi];
      end else begin : g_a_pass
        assign a_in[gi][gj] = a_q[gi][gj-1];
      end
      if (gi == 0) begin : g_b_top
        assign b_in[gi][gj] = b_edge[gj];
      end else begin : g_b_pass
        assign b_in[gi][gj] = b_q[gi-1][gj];
      end
      assign acc_nxt[gi][gj] = mac(acc[gi][gj], a_in[gi][gj], b_in[gi][gj], sgn_q);
    end
  end

  // Array state moves on every busy cycle; idle beats carry zeros, so stalls are harmless.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      for (int i = 0; i < ROWS; i++)
        for (int k = 0; k < ROWS; k++)
          a_sk[i][k] <= '0;
      for (int j = 0; j < COLS; j++)
        for (int k = 0; k < COLS; k++)
          b_sk[j][k] <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          acc[i][j] <= '0;
        end
    end else if (advance) begin
      for (int i = 0; i < ROWS; i++) begin
        a_sk[i][0] <= a_inj[i];
        for (int k = 1; k < ROWS; k++)
          a_sk[i][k] <= a_sk[i][k-1];
      end
      for (int j = 0; j < COLS; j++) begin
        b_sk[j][0] <= b_inj[j];
        for (int k = 1; k < COLS; k++)
          b_sk[j][k] <= b_sk[j][k-1];
      end
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j] <= a_in[i][j];
          b_q[i][j] <= b_in[i][j];
          acc[i][j] <= acc_nxt[i][j];
        end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      k_len_q      <= '0;
      sgn_q        <= 1'b0;
      beat_cnt     <= '0;
      flush_cnt    <= '0;
      out_row_idx  <= '0;
      cycles_count <= '0;
    end else begin
      if (launch)
        cycles_count <= '0;
      else if (advance)
        cycles_count <= cycles_count + 32'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            k_len_q     <= k_len;
            sgn_q       <= signed_mode;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            out_row_idx <= '0;
            state       <= (k_len == '0) ? S_FLUSH : S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            beat_cnt <= beat_cnt + KLEN_W'(1);
            if (beat_cnt == k_len_q - KLEN_W'(1))
              state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt + FC_W'(1);
          if (flush_cnt == FC_W'(FLUSH_LEN - 1))
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_row_idx == RI_W'(ROWS - 1))
              state <= S_DONE;
            else
              out_row_idx <= out_row_idx + RI_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_row = '0;
    if (out_valid)
      for (int j = 0; j < COLS; j++)
        out_row[j*OP_W +: OP_W] = acc[out_row_idx][j];
  end

endmodule
